// File: rtl/pulse_stretcher.sv
// Stretches single-cycle event pulses into HOLD_CYCLES-wide output assertions separated
// by GAP_CYCLES low intervals, replaying events that arrive while busy from a saturating queue.
module pulse_stretcher #(
    parameter int HOLD_CYCLES = 8,
    parameter int GAP_CYCLES  = 4,
    parameter int PEND_W      = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ev_1p,
    input  logic              en,
    input  logic              ovf_clr,
    output logic              out,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    localparam int MAXC  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC) : 1;

    typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_t;

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic               out_d;
    logic               acc, cnt_zero, launch, inc, dec, pend_full, ovf_set;

    assign acc       = ev_1p & en;
    assign cnt_zero  = (cnt == '0);
    assign pend_full = &pending;
    // Last GAP cycle relaunches from the queue or from an event arriving right now.
    assign launch    = (state == GAP) && cnt_zero && en && ((pending != '0) || ev_1p);
    assign inc       = acc && (state != IDLE);
    assign dec       = launch;
    assign ovf_set   = inc && !dec && pend_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            out   <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            out   <= out_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        unique case (state)
            IDLE: begin
                if (acc) begin
                    state_d = ACTIVE;
                    cnt_d   = CNT_W'(HOLD_CYCLES - 1);
                end
            end
            ACTIVE: begin
                if (cnt_zero) begin
                    state_d = GAP;
                    cnt_d   = CNT_W'(GAP_CYCLES - 1);
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            GAP: begin
                if (!cnt_zero) begin
                    cnt_d = cnt - 1'b1;
                end else if (launch) begin
                    state_d = ACTIVE;
                    cnt_d   = CNT_W'(HOLD_CYCLES - 1);
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        out_d = (state_d == ACTIVE);
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            if (!en)
                pending <= '0;
            else if (inc && !dec && !pend_full)
                pending <= pending + PEND_W'(1);
            else if (dec && !inc)
                pending <= pending - PEND_W'(1);

            if (ovf_set)
                overflow <= 1'b1;
            else if (ovf_clr)
                overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Bench for pulse_stretcher: timeline-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_pulse_stretcher;

    localparam int HOLD = 8;
    localparam int GAP  = 4;
    localparam int PW   = 3;
    localparam int MAXP = (1 << PW) - 1;

    logic          clk, rst_n, ev_1p, en, ovf_clr;
    logic          out, busy, overflow;
    logic [PW-1:0] pending;

    int checks = 0;
    int errors = 0;

    // Model: absolute start cycle of the current assertion, queue depth, overflow flag.
    int cyc;
    int m_start;
    int m_pend;
    bit m_ovf;

    pulse_stretcher #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .PEND_W(PW)) dut (
        .clk(clk), .rst_n(rst_n), .ev_1p(ev_1p), .en(en), .ovf_clr(ovf_clr),
        .out(out), .busy(busy), .pending(pending), .overflow(overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin : model
        int  last, ns, np;
        bit  acc, busy_now, set;
        if (!rst_n) begin
            cyc     <= 0;
            m_start <= -1000;
            m_pend  <= 0;
            m_ovf   <= 1'b0;
        end else begin
            last     = m_start + HOLD + GAP - 1;
            busy_now = (cyc >= m_start) && (cyc <= last);
            acc      = ev_1p && en;
            ns       = m_start;
            np       = m_pend;
            set      = 1'b0;
            if (cyc == last && en && (m_pend > 0 || acc)) begin
                ns = cyc + 1;
                if (!acc) np = m_pend - 1;
            end else if (acc && busy_now) begin
                if (m_pend == MAXP) set = 1'b1;
                else np = m_pend + 1;
            end else if (acc) begin
                ns = cyc + 1;
            end
            if (!en) np = 0;
            m_start <= ns;
            m_pend  <= np;
            m_ovf   <= set ? 1'b1 : (ovf_clr ? 1'b0 : m_ovf);
            cyc     <= cyc + 1;
        end
    end

    always @(negedge clk) begin
        chk("model_out", int'(out), int'(cyc >= m_start && cyc < m_start + HOLD));
        chk("model_busy", int'(busy), int'(cyc >= m_start && cyc <= m_start + HOLD + GAP - 1));
        chk("model_pending", int'(pending), m_pend);
        chk("model_overflow", int'(overflow), int'(m_ovf));
    end

    task automatic tick(input logic e, input logic en_v, input logic clr);
        ev_1p   = e;
        en      = en_v;
        ovf_clr = clr;
        @(negedge clk);
    endtask

    task automatic at_cycle(input int c);
        while (cyc < c) tick(1'b0, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        ev_1p = 1'b0; en = 1'b1; ovf_clr = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int k;
        rst_n = 1'b1; ev_1p = 1'b0; en = 1'b1; ovf_clr = 1'b0;
        #2;
        do_reset();
        chk("reset_out", int'(out), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_pending", int'(pending), 0);
        chk("reset_overflow", int'(overflow), 0);

        // Single event at cycle 10
        at_cycle(10); tick(1'b1, 1'b1, 1'b0);
        chk("t1_out_c11", int'(out), 1);
        at_cycle(18); chk("t1_out_c18", int'(out), 1);
        at_cycle(19); chk("t1_out_c19", int'(out), 0);
        at_cycle(22); chk("t1_busy_c22", int'(busy), 1);
        at_cycle(23); chk("t1_busy_c23", int'(busy), 0);

        // Events at 10, 12, 14
        do_reset();
        at_cycle(10); tick(1'b1, 1'b1, 1'b0);
        at_cycle(12); tick(1'b1, 1'b1, 1'b0);
        at_cycle(14); tick(1'b1, 1'b1, 1'b0);
        chk("t2_pend_c15", int'(pending), 2);
        at_cycle(23); chk("t2_out_c23", int'(out), 1); chk("t2_pend_c23", int'(pending), 1);
        at_cycle(35); chk("t2_out_c35", int'(out), 1); chk("t2_pend_c35", int'(pending), 0);
        at_cycle(46); chk("t2_busy_c46", int'(busy), 1);
        at_cycle(47); chk("t2_busy_c47", int'(busy), 0);

        // Saturation and sticky overflow: events in cycles 10..19
        do_reset();
        at_cycle(10); repeat (10) tick(1'b1, 1'b1, 1'b0);
        chk("t3_pend_sat", int'(pending), 7);
        chk("t3_ovf_set", int'(overflow), 1);
        k = 0;
        while (busy && k < 300) begin tick(1'b0, 1'b1, 1'b0); k++; end
        chk("t3_drain_timeout", int'(k < 300), 1);
        chk("t3_drain_cycles", k, 8 * (HOLD + GAP) - (20 - 11));
        chk("t3_pend_drained", int'(pending), 0);
        chk("t3_ovf_sticky", int'(overflow), 1);
        tick(1'b0, 1'b1, 1'b1);
        chk("t3_ovf_cleared", int'(overflow), 0);

        // Event exactly in the last GAP cycle with empty queue
        do_reset();
        at_cycle(10); tick(1'b1, 1'b1, 1'b0);
        at_cycle(22); tick(1'b1, 1'b1, 1'b0);
        chk("t4_out_c23", int'(out), 1);
        chk("t4_pend_c23", int'(pending), 0);
        at_cycle(30); chk("t4_out_c30", int'(out), 1);
        at_cycle(31); chk("t4_out_c31", int'(out), 0);

        // Asynchronous reset mid-ACTIVE with a queue
        do_reset();
        at_cycle(10); repeat (3) tick(1'b1, 1'b1, 1'b0);
        at_cycle(14);
        chk("t5_pend_pre", int'(pending), 2);
        rst_n = 1'b0;
        #1;
        chk("t5_out_async", int'(out), 0);
        chk("t5_busy_async", int'(busy), 0);
        chk("t5_pend_async", int'(pending), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) tick(1'b0, 1'b1, 1'b0);
        chk("t5_no_replay", int'(busy), 0);

        // en=0 flushes queue, current sequence completes
        do_reset();
        at_cycle(10); repeat (4) tick(1'b1, 1'b1, 1'b0);
        chk("t6_pend_c14", int'(pending), 3);
        at_cycle(15); tick(1'b1, 1'b0, 1'b0);
        chk("t6_pend_c16", int'(pending), 0);
        while (cyc < 26) begin
            if (cyc == 18) chk("t6_out_c18", int'(out), 1);
            if (cyc == 19) chk("t6_out_c19", int'(out), 0);
            if (cyc == 22) chk("t6_busy_c22", int'(busy), 1);
            if (cyc == 23) chk("t6_busy_c23", int'(busy), 0);
            tick(1'b1, 1'b0, 1'b0);
        end
        chk("t6_idle_c26", int'(busy), 0);
        chk("t6_ovf_c26", int'(overflow), 0);
        repeat (5) tick(1'b0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
